// File: rtl/board_ram_arbiter.sv
// rtl/board_ram_arbiter.sv - round-robin burst arbiter for the shared board RAM
module board_ram_arbiter #(
    parameter int N       = 3,
    parameter int AW      = 8,
    parameter int DW      = 6,
    parameter int DEPTH   = 220,
    parameter int TIMEOUT = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N-1:0]    req,
    input  logic [N-1:0]    we,
    input  logic [N-1:0]    last,
    input  logic [N*AW-1:0] addr,
    input  logic [N*DW-1:0] wdata,
    output logic [N-1:0]    gnt,
    output logic [N-1:0]    rvalid,
    output logic [DW-1:0]   rdata,
    output logic            err_timeout,
    output logic            err_oob,
    output logic [AW-1:0]   ram_addr,
    output logic [DW-1:0]   ram_in,
    output logic            ram_wren,
    input  logic [DW-1:0]   ram_out
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;
    localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        state, state_next;
    logic [PW-1:0] ptr, ptr_next, pick_idx, cand, own_idx;
    logic          pick_found;
    logic [WW-1:0] wd, wd_next;
    logic [N-1:0]  gnt_next, rvalid_next;
    logic          err_timeout_next, err_oob_next;
    logic [AW-1:0] addr_a [N];
    logic [DW-1:0] wdata_a [N];
    logic [AW-1:0] own_addr;
    logic [DW-1:0] own_wdata;
    logic          own_oob, access;

    for (genvar k = 0; k < N; k++) begin : g_split
        assign addr_a[k]  = addr[k*AW +: AW];
        assign wdata_a[k] = wdata[k*DW +: DW];
    end

    assign rdata = ram_out;

    // First requester at or after ptr, wrapping.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int i = 0; i < N; i++) begin
            cand = PW'((int'(ptr) + i) % N);
            if (!pick_found && req[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    always_comb begin
        own_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (gnt[i]) own_idx = PW'(i);
        end
    end

    assign own_addr  = addr_a[own_idx];
    assign own_wdata = wdata_a[own_idx];
    assign own_oob   = {{(32-AW){1'b0}}, own_addr} >= 32'(DEPTH);
    assign access    = (state == BUSY) && req[own_idx];

    always_comb begin
        state_next       = state;
        gnt_next         = gnt;
        ptr_next         = ptr;
        wd_next          = wd;
        rvalid_next      = '0;
        err_oob_next     = 1'b0;
        err_timeout_next = err_timeout;
        ram_addr         = '0;
        ram_in           = '0;
        ram_wren         = 1'b0;
        case (state)
            IDLE: begin
                wd_next = '0;
                if (pick_found) begin
                    gnt_next           = '0;
                    gnt_next[pick_idx] = 1'b1;
                    state_next         = BUSY;
                    ptr_next           = (int'(pick_idx) == N - 1) ? '0 : pick_idx + 1'b1;
                end
            end
            BUSY: begin
                if (access) begin
                    ram_addr              = own_addr;
                    ram_in                = own_wdata;
                    ram_wren              = we[own_idx] & ~own_oob;
                    wd_next               = '0;
                    rvalid_next[own_idx]  = ~we[own_idx];
                    err_oob_next          = own_oob;
                    if (last[own_idx]) begin
                        gnt_next   = '0;
                        state_next = IDLE;
                    end
                end else if (wd == WW'(TIMEOUT - 1)) begin
                    // Owner went quiet for too long: take the RAM back.
                    gnt_next         = '0;
                    state_next       = IDLE;
                    wd_next          = '0;
                    err_timeout_next = 1'b1;
                end else begin
                    wd_next = wd + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            gnt         <= '0;
            rvalid      <= '0;
            ptr         <= '0;
            wd          <= '0;
            err_timeout <= 1'b0;
            err_oob     <= 1'b0;
        end else begin
            state       <= state_next;
            gnt         <= gnt_next;
            rvalid      <= rvalid_next;
            ptr         <= ptr_next;
            wd          <= wd_next;
            err_timeout <= err_timeout_next;
            err_oob     <= err_oob_next;
        end
    end
endmodule

// File: tb/tb_board_ram_arbiter.sv
// tb/tb_board_ram_arbiter.sv - self-checking bench for board_ram_arbiter
module tb_board_ram_arbiter;
    localparam int N = 3, AW = 8, DW = 6, DEPTH = 220, TIMEOUT = 64;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [N-1:0]    req = '0, we = '0, last = '0;
    logic [N*AW-1:0] addr = '0;
    logic [N*DW-1:0] wdata = '0;
    logic [N-1:0]    gnt, rvalid;
    logic [DW-1:0]   rdata, ram_in, ram_out;
    logic [AW-1:0]   ram_addr;
    logic            err_timeout, err_oob, ram_wren;

    logic [DW-1:0]   ram_mem [256];
    logic [DW-1:0]   shadow [256];

    int n_chk = 0, n_fail = 0;
    int wren_cnt = 0, other_gnt = 0, rv0_cnt = 0, nz_cnt = 0, oob_cnt = 0;

    always #5 clk = ~clk;

    board_ram_arbiter #(.N(N), .AW(AW), .DW(DW), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .last(last), .addr(addr),
        .wdata(wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
        .err_timeout(err_timeout), .err_oob(err_oob), .ram_addr(ram_addr),
        .ram_in(ram_in), .ram_wren(ram_wren), .ram_out(ram_out)
    );

    // ram_board stand-in: registered inputs, one-cycle read latency
    initial begin
        for (int i = 0; i < 256; i++) ram_mem[i] = DW'((i * 7 + 3) % 64);
        ram_mem[8'h15] = 6'h2A;
        ram_mem[230]   = 6'h15;
        for (int i = 0; i < 256; i++) shadow[i] = ram_mem[i];
    end

    always @(posedge clk) begin
        if (ram_wren) ram_mem[ram_addr] <= ram_in;
        ram_out <= ram_mem[ram_addr];
    end

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: owner index, rotating pointer, idle-cycle count, shadow RAM
    int           m_owner = -1, m_ptr = 0, m_idle = 0;
    logic [N-1:0] m_rv = '0;
    bit           m_tmo = 0, m_oob = 0, m_rchk = 0;
    int           m_rexp = 0;

    always @(posedge clk or posedge reset) begin
        int k, a;
        bit found;
        if (reset) begin
            m_owner = -1; m_ptr = 0; m_idle = 0; m_rv = '0;
            m_tmo = 0; m_oob = 0; m_rchk = 0;
        end else begin
            m_rv = '0; m_oob = 0; m_rchk = 0;
            if (m_owner < 0) begin
                found = 0;
                for (int i = 0; i < N; i++) begin
                    k = (m_ptr + i) % N;
                    if (!found && req[k]) begin
                        found = 1;
                        m_owner = k;
                        m_ptr = (k + 1) % N;
                    end
                end
            end else begin
                k = m_owner;
                if (req[k]) begin
                    m_idle = 0;
                    a = int'(addr[k*AW +: AW]);
                    if (a >= DEPTH) m_oob = 1;
                    if (we[k]) begin
                        if (a < DEPTH) shadow[a] = wdata[k*DW +: DW];
                    end else begin
                        m_rv[k] = 1'b1;
                        m_rchk = (a < DEPTH);
                        m_rexp = int'(shadow[a]);
                    end
                    if (last[k]) m_owner = -1;
                end else begin
                    m_idle++;
                    if (m_idle == TIMEOUT) begin
                        m_owner = -1;
                        m_idle = 0;
                        m_tmo = 1;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        int e_gnt, e_wren, e_addr, e_in, k;
        e_gnt = (m_owner < 0) ? 0 : (1 << m_owner);
        chk("gnt", int'(gnt), e_gnt);
        chk("rvalid", int'(rvalid), int'(m_rv));
        chk("err_timeout", int'(err_timeout), int'(m_tmo));
        chk("err_oob", int'(err_oob), int'(m_oob));
        if (m_rchk) chk("rdata", int'(rdata), m_rexp);
        e_wren = 0; e_addr = 0; e_in = 0;
        if (m_owner >= 0 && req[m_owner]) begin
            k = m_owner;
            e_addr = int'(addr[k*AW +: AW]);
            e_in   = int'(wdata[k*DW +: DW]);
            e_wren = (we[k] && e_addr < DEPTH) ? 1 : 0;
        end
        chk("ram_wren", int'(ram_wren), e_wren);
        chk("ram_addr", int'(ram_addr), e_addr);
        chk("ram_in", int'(ram_in), e_in);
        if (ram_wren) wren_cnt++;
        if (gnt[1] || gnt[2]) other_gnt++;
        if (rvalid[0]) begin
            rv0_cnt++;
            if (rdata != '0) nz_cnt++;
        end
        if (err_oob) oob_cnt++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int k, input bit w, input bit l, input int a, input int d);
        req[k] = 1'b1;
        we[k] = w;
        last[k] = l;
        addr[k*AW +: AW] = AW'(a);
        wdata[k*DW +: DW] = DW'(d);
    endtask

    task automatic clear_all();
        req = '0; we = '0; last = '0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "bench time limit");
    end

    initial begin
        int seq [8];
        int exp_seq [8] = '{1, 0, 2, 0, 4, 0, 1, 0};
        int cnt;
        repeat (3) step();
        chk("rst_gnt", int'(gnt), 0);
        chk("rst_rvalid", int'(rvalid), 0);
        chk("rst_err_timeout", int'(err_timeout), 0);
        chk("rst_err_oob", int'(err_oob), 0);
        reset = 1'b0;

        // single read
        drive(1, 0, 1, 'h15, 0);
        step();
        chk("t1_gnt", int'(gnt), 2);
        step();
        clear_all();
        chk("t1_rvalid", int'(rvalid), 2);
        chk("t1_rdata", int'(rdata), 'h2A);
        chk("t1_release", int'(gnt), 0);
        step();

        // burst write of the whole board to zero
        drive(0, 1, 0, 0, 0);
        step();
        chk("t2_gnt0", int'(gnt), 1);
        drive(1, 0, 0, 5, 0);
        drive(2, 0, 0, 7, 0);
        wren_cnt = 0; other_gnt = 0;
        for (int a = 0; a < DEPTH; a++) begin
            drive(0, 1, a == DEPTH - 1, a, 0);
            step();
        end
        clear_all();
        chk("t2_wren_cycles", wren_cnt, 220);
        chk("t2_no_other_gnt", other_gnt, 0);
        step();
        drive(0, 0, 0, 0, 0);
        step();
        rv0_cnt = 0; nz_cnt = 0;
        for (int a = 0; a < DEPTH; a++) begin
            drive(0, 0, a == DEPTH - 1, a, 0);
            step();
        end
        clear_all();
        step();
        chk("t2_readback_count", rv0_cnt, 220);
        chk("t2_readback_nonzero", nz_cnt, 0);

        // round robin from a fresh pointer
        reset = 1'b1;
        step();
        reset = 1'b0;
        drive(0, 0, 1, 1, 0);
        drive(1, 0, 1, 2, 0);
        drive(2, 0, 1, 3, 0);
        for (int i = 0; i < 8; i++) begin
            step();
            seq[i] = int'(gnt);
        end
        clear_all();
        for (int i = 0; i < 8; i++) chk($sformatf("t3_rr_%0d", i), seq[i], exp_seq[i]);
        step();

        // watchdog
        drive(2, 0, 0, 9, 0);
        step();
        chk("t4_gnt2", int'(gnt), 4);
        chk("t4_tmo_before", int'(err_timeout), 0);
        clear_all();
        cnt = 1;
        while (gnt[2] && cnt < 200) begin
            step();
            if (gnt[2]) cnt++;
        end
        chk("t4_hold_cycles", cnt, 64);
        chk("t4_tmo_set", int'(err_timeout), 1);
        drive(0, 0, 1, 4, 0);
        step();
        chk("t4_next_gnt", int'(gnt), 1);
        step();
        clear_all();
        chk("t4_tmo_sticky", int'(err_timeout), 1);
        step();

        // out-of-range write
        oob_cnt = 0; wren_cnt = 0;
        drive(0, 1, 1, 230, 'h3F);
        step();
        chk("t5_gnt", int'(gnt), 1);
        step();
        clear_all();
        repeat (3) step();
        chk("t5_no_wren", wren_cnt, 0);
        chk("t5_oob_pulses", oob_cnt, 1);
        chk("t5_ram_kept", int'(ram_mem[230]), 'h15);

        // reset in the middle of a read burst
        drive(1, 0, 0, 10, 0);
        step();
        chk("t6_gnt1", int'(gnt), 2);
        drive(1, 0, 0, 11, 0);
        step();
        drive(1, 0, 0, 12, 0);
        #2;
        reset = 1'b1;
        #1;
        chk("t6_gnt_drop", int'(gnt), 0);
        chk("t6_rvalid_drop", int'(rvalid), 0);
        clear_all();
        step();
        reset = 1'b0;
        drive(0, 0, 1, 1, 0);
        drive(1, 0, 1, 2, 0);
        drive(2, 0, 1, 3, 0);
        step();
        chk("t6_winner0", int'(gnt), 1);
        step();
        clear_all();
        step();

        // randomized traffic with occasional quiet owners
        for (int c = 0; c < 3000; c++) begin
            if (c % 500 == 250) begin
                clear_all();
                drive(int'($urandom_range(0, N - 1)), 0, 0, 0, 0);
                step();
                clear_all();
                repeat (70) step();
            end
            for (int k = 0; k < N; k++) begin
                req[k]  = ($urandom_range(0, 3) != 0);
                we[k]   = ($urandom_range(0, 1) != 0);
                last[k] = ($urandom_range(0, 3) == 0);
                addr[k*AW +: AW] = ($urandom_range(0, 9) == 0) ?
                                   AW'($urandom_range(DEPTH, 255)) : AW'($urandom_range(0, DEPTH - 1));
                wdata[k*DW +: DW] = DW'($urandom_range(0, 63));
            end
            step();
        end
        clear_all();
        repeat (3) step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
